// File: rtl/apu_lfo_pkg.sv
// Shared constants and step-event decode for the apu_lfo_seq frame sequencer.
package apu_lfo_pkg;

    localparam logic LFO_MODE4     = 1'b0;
    localparam logic LFO_MODE5     = 1'b1;
    localparam int   LFO_STEPS4    = 4;
    localparam int   LFO_STEPS5    = 5;
    localparam int   STEP_LEN_REAL = 3729;

    typedef struct packed {
        logic quarter;
        logic half;
        logic irq;
    } lfo_ev_t;

    // Events fired when the given step reaches its terminal tick.
    function automatic lfo_ev_t lfo_events(input logic mode, input logic [2:0] step);
        lfo_ev_t ev;
        ev = '0;
        if (mode == LFO_MODE4) begin
            case (step)
                3'd0, 3'd2: ev.quarter = 1'b1;
                3'd1: begin
                    ev.quarter = 1'b1;
                    ev.half    = 1'b1;
                end
                3'd3: begin
                    ev.quarter = 1'b1;
                    ev.half    = 1'b1;
                    ev.irq     = 1'b1;
                end
                default: ev = '0;
            endcase
        end else begin
            case (step)
                3'd0, 3'd2: ev.quarter = 1'b1;
                3'd1, 3'd4: begin
                    ev.quarter = 1'b1;
                    ev.half    = 1'b1;
                end
                default: ev = '0;
            endcase
        end
        return ev;
    endfunction

    function automatic logic [2:0] lfo_last_step(input logic mode);
        return (mode == LFO_MODE5) ? 3'(LFO_STEPS5 - 1) : 3'(LFO_STEPS4 - 1);
    endfunction

endpackage

// File: rtl/apu_lfo_div.sv
// Intra-step ACLK divider: counts enabled ticks and flags the terminal one.
module apu_lfo_div #(
    parameter int CNT_W    = 12,
    parameter int STEP_LEN = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_LEN - 1);

    logic [CNT_W-1:0] cnt_reg;

    // A clear swallows a coincident tick, so no terminal pulse either.
    assign term = en && !clr && (cnt_reg == LAST);
    assign cnt  = cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/apu_lfo_seq.sv
// Frame sequencer: quarter/half-frame strobes and frame IRQ.
// Define APU_LFO_OBS_EN to expose STEP_OBS / CNT_OBS observation ports.
module apu_lfo_seq
    import apu_lfo_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int STEP_LEN = 4
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             ACLK_EN,
    input  logic             W4017,
    input  logic             DIN_MODE,
    input  logic             DIN_IRQDIS,
    input  logic             IRQ_ACK,
    output logic             nLFO1,
    output logic             nLFO2,
    output logic             INT
`ifdef APU_LFO_OBS_EN
    ,
    output logic [2:0]       STEP_OBS,
    output logic [CNT_W-1:0] CNT_OBS
`endif
);

    logic [CNT_W-1:0] cnt_val;
    logic             term;
    logic [2:0]       step_reg;
    logic             mode_reg;
    logic             irqdis_reg;
    logic             int_reg;
    logic             nlfo1_reg;
    logic             nlfo2_reg;
    lfo_ev_t          ev;
    logic             int_set;
    logic             int_clr;

    apu_lfo_div #(
        .CNT_W    (CNT_W),
        .STEP_LEN (STEP_LEN)
    ) u_div (
        .clk  (CLK),
        .srst (RES),
        .en   (ACLK_EN),
        .clr  (W4017),
        .cnt  (cnt_val),
        .term (term)
    );

    assign ev      = lfo_events(mode_reg, step_reg);
    assign int_set = term && ev.irq && !irqdis_reg;
    assign int_clr = IRQ_ACK || (W4017 && DIN_IRQDIS);

    always_ff @(posedge CLK) begin
        if (RES) begin
            step_reg   <= '0;
            mode_reg   <= LFO_MODE4;
            irqdis_reg <= 1'b0;
            int_reg    <= 1'b0;
            nlfo1_reg  <= 1'b1;
            nlfo2_reg  <= 1'b1;
        end else begin
            nlfo1_reg <= 1'b1;
            nlfo2_reg <= 1'b1;
            // Setting beats a same-cycle acknowledge.
            if (int_set) begin
                int_reg <= 1'b1;
            end else if (int_clr) begin
                int_reg <= 1'b0;
            end
            if (W4017) begin
                mode_reg   <= DIN_MODE;
                irqdis_reg <= DIN_IRQDIS;
                step_reg   <= '0;
                if (DIN_MODE == LFO_MODE5) begin
                    nlfo1_reg <= 1'b0;
                    nlfo2_reg <= 1'b0;
                end
            end else if (term) begin
                nlfo1_reg <= !ev.quarter;
                nlfo2_reg <= !ev.half;
                step_reg  <= (step_reg >= lfo_last_step(mode_reg)) ? 3'd0 : step_reg + 3'd1;
            end
        end
    end

    assign nLFO1 = nlfo1_reg;
    assign nLFO2 = nlfo2_reg;
    assign INT   = int_reg;

`ifdef APU_LFO_OBS_EN
    assign STEP_OBS = step_reg;
    assign CNT_OBS  = cnt_val;
`else
    logic cnt_unused;
    assign cnt_unused = ^cnt_val;
`endif

endmodule

// File: doc/apu_lfo_seq.md
Name: apu_lfo_seq

Overview:
- Parametrised successor to the bogus LFO generator: a frame sequencer producing active-low quarter-frame (nLFO1) and half-frame (nLFO2) strobes.
- Period is programmable: small STEP_LEN for accelerated tests, 3729 for real timing.
- Adds 4-step/5-step mode, a $4017-style write, and a frame IRQ with inhibit/acknowledge.
- Sits between the APU clock divider (ACLK enable) and the envelope, length and sweep units.

Parameters:
- CNT_W, 12, width of the intra-step ACLK counter; must satisfy 2^CNT_W >= STEP_LEN.
- STEP_LEN, 4, ACLK ticks per sequencer step (3729 = real hardware; small = accelerated tests).

Ports:
- CLK  in  1  single system clock; all state updates on posedge CLK.
- RES  in  1  synchronous active-high reset.
- ACLK_EN  in  1  one-CLK-wide APU-clock enable; replaces the nACLK2 edge clocking.
- W4017  in  1  one-cycle register write strobe.
- DIN_MODE  in  1  mode bit written with W4017 (0 = 4-step, 1 = 5-step).
- DIN_IRQDIS  in  1  IRQ inhibit bit written with W4017.
- IRQ_ACK  in  1  one-cycle frame-IRQ acknowledge (status read).
- nLFO1  out  1  quarter-frame strobe, active low, one CLK wide.
- nLFO2  out  1  half-frame strobe, active low, one CLK wide.
- INT  out  1  frame IRQ flag, active high.

Behaviour:
- Reset (RES=1 at posedge CLK): cnt=0, step=0, mode=0, irqdis=0, INT=0, nLFO1=1, nLFO2=1. RES overrides every other input.
- Registers: cnt[CNT_W-1:0], step[2:0], mode, irqdis, INT. Outputs are registered, with no combinational path from inputs.
- Tick (ACLK_EN=1, no write):
  - If cnt != STEP_LEN-1: cnt += 1.
  - Else: cnt = 0 and a step event fires for the current step; step then advances.
  - Step wraps 3->0 in 4-step mode and 4->0 in 5-step mode.
- Step events in 4-step mode:
  - Steps 0 and 2: quarter only.
  - Steps 1 and 3: quarter + half.
  - Step 3: also sets INT when irqdis=0.
- Step events in 5-step mode:
  - Steps 0 and 2: quarter.
  - Steps 1 and 4: quarter + half.
  - Step 3: no event.
  - INT is never set.
- Strobes: on a step event, the matching nLFOx goes low in the cycle after the posedge that processed the terminal tick. It returns high on the next posedge, so each strobe is exactly one CLK wide whatever the ACLK_EN spacing.
- W4017:
  - Latches mode=DIN_MODE and irqdis=DIN_IRQDIS.
  - Clears cnt=0, step=0.
  - If DIN_IRQDIS=1, clears INT.
  - If DIN_MODE=1, fires quarter + half strobes immediately (low on the following cycle).
  - W4017 takes priority over a coincident ACLK_EN tick; that tick is dropped.
- IRQ_ACK clears INT. If a set and IRQ_ACK occur in the same cycle, the set wins.
- Latency: write-to-strobe is 1 CLK. Terminal tick to strobe is 1 CLK.
- Mid-operation reset: strobes in flight are cancelled (outputs high on the next cycle).

Optional Feature:
- APU_LFO_OBS_EN defined:
  - Adds output ports STEP_OBS[2:0] (current step) and CNT_OBS[CNT_W-1:0] (current cnt), driven directly from the registers.
- Not defined:
  - The ports are absent.
  - Core behaviour is identical either way.

Decomposition:
- Package apu_lfo_pkg:
  - Mode constants LFO_MODE4=0 and LFO_MODE5=1.
  - Step-count constants (4 and 5).
  - Constant STEP_LEN_REAL=3729.
  - Function returning the {quarter, half, irq} event bits for a (mode, step) pair.
- One sub-module, apu_lfo_div: the parametrised cnt/terminal-count divider (enable, clear, terminal pulse). The step sequencer and IRQ logic stay in the top module.

Test Plan:
- Reset / first event: RES for 2 cycles, then ACLK_EN every 2nd cycle, STEP_LEN=4, mode 0 -> nLFO1 low for exactly 1 CLK after the 4th tick; nLFO2 stays high; INT=0.
- Full 4-step frame: 16 ticks, mode 0 -> 4 nLFO1 pulses, nLFO2 after ticks 8 and 16, INT rises after tick 16 and holds; IRQ_ACK -> INT=0 next cycle.
- 5-step mode: W4017 with DIN_MODE=1 -> nLFO1 and nLFO2 low on the next cycle; over 20 further ticks -> nLFO1 after ticks 4, 8, 12, 20; nLFO2 after ticks 8 and 20; no pulse at tick 16; INT stays 0.
- IRQ inhibit: reach step 3 with INT=1, then W4017 with DIN_IRQDIS=1 -> INT=0; next 16 ticks -> INT stays 0.
- Simultaneous events: W4017 (mode 0) in the same cycle as a terminal ACLK_EN -> no strobe, cnt=0, step=0. IRQ_ACK in the same cycle as the INT set -> INT=1.
- Mid-operation reset: RES asserted at cnt=2, step=2 -> outputs high and INT=0 next cycle; the first strobe comes 4 ticks after release.
